// File: rtl/dbg_dump_reader.sv
// Debug-port reader: walks rdbg_addr from BASE_ADDR and streams each captured word out over valid/ready.
// Build option DBG_DUMP_CHECKSUM_EN keeps the running checksum of accepted words; otherwise checksum reads 0.
module dbg_dump_reader #(
    parameter logic [31:0] BASE_ADDR = 32'h0,
    parameter int          COUNT     = 32,
    parameter logic [31:0] STRIDE    = 32'd1,
    parameter int          READ_LAT  = 1
) (
    input  logic        clk_100M,
    input  logic        rst_n,
    input  logic        clk_en,
    input  logic        start,
    output logic [31:0] rdbg_addr,
    input  logic [31:0] rdbg_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_addr,
    output logic [31:0] out_data,
    output logic        out_last,
    output logic        busy,
    output logic        done,
    output logic [31:0] checksum
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_ISSUE   = 3'd1;
    localparam logic [2:0] S_WAIT    = 3'd2;
    localparam logic [2:0] S_PRESENT = 3'd3;
    localparam logic [2:0] S_DONE    = 3'd4;

    localparam logic [15:0] LAST_IDX = 16'(COUNT - 1);
    localparam logic [2:0]  LAT_INIT = 3'(READ_LAT - 1);

    logic [2:0]  r_state;
    logic [31:0] r_addr;
    logic [15:0] r_idx;
    logic [2:0]  r_lat;
    logic        r_outValid;
    logic [31:0] r_outAddr;
    logic [31:0] r_outData;
    logic        r_outLast;
    logic        r_busy;
    logic        r_done;
    logic        w_xfer;

    assign w_xfer = (r_state == S_PRESENT) && out_ready;

    // The latency counter is tested before it is decremented, so the capture lands
    // READ_LAT enabled cycles after ISSUE.
    always_ff @(posedge clk_100M or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_addr     <= BASE_ADDR;
            r_idx      <= 16'd0;
            r_lat      <= 3'd0;
            r_outValid <= 1'b0;
            r_outAddr  <= 32'h0;
            r_outData  <= 32'h0;
            r_outLast  <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else if (clk_en) begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_state <= S_ISSUE;
                        r_addr  <= BASE_ADDR;
                        r_idx   <= 16'd0;
                        r_busy  <= 1'b1;
                    end
                end
                S_ISSUE: begin
                    r_lat   <= LAT_INIT;
                    r_state <= S_WAIT;
                end
                S_WAIT: begin
                    if (r_lat == 3'd0) begin
                        r_outAddr  <= r_addr;
                        r_outData  <= rdbg_data;
                        r_outValid <= 1'b1;
                        r_outLast  <= (r_idx == LAST_IDX);
                        r_state    <= S_PRESENT;
                    end else begin
                        r_lat <= r_lat - 3'd1;
                    end
                end
                S_PRESENT: begin
                    if (w_xfer) begin
                        r_outValid <= 1'b0;
                        r_outLast  <= 1'b0;
                        if (r_idx == LAST_IDX) begin
                            r_state <= S_DONE;
                            r_done  <= 1'b1;
                        end else begin
                            r_addr  <= r_addr + STRIDE;
                            r_idx   <= r_idx + 16'd1;
                            r_state <= S_ISSUE;
                        end
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

`ifdef DBG_DUMP_CHECKSUM_EN
    logic [31:0] r_checksum;

    always_ff @(posedge clk_100M or negedge rst_n) begin
        if (!rst_n) begin
            r_checksum <= 32'h0;
        end else if (clk_en) begin
            if ((r_state == S_IDLE) && start) begin
                r_checksum <= 32'h0;
            end else if (w_xfer) begin
                r_checksum <= r_checksum + r_outData;
            end
        end
    end

    assign checksum = r_checksum;
`else
    assign checksum = 32'h0;
`endif

    assign rdbg_addr = r_addr;
    assign out_valid = r_outValid;
    assign out_addr  = r_outAddr;
    assign out_data  = r_outData;
    assign out_last  = r_outLast;
    assign busy      = r_busy;
    assign done      = r_done;

endmodule

// File: tb/tb_dbg_dump_reader.sv
// Self-checking bench for dbg_dump_reader: three instances cover the basic/latency-stride/wrap configurations,
// each fed by a read model that only returns addr*0x11111111 once READ_LAT enabled cycles have elapsed.
module tb_dbg_dump_reader;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
        logic        last;
    } exp_t;

    logic clk_100M = 1'b0;
    always #5 clk_100M = ~clk_100M;

    logic             rst_n;
    logic             clk_en;
    logic             out_ready;
    logic [2:0]       startV;
    logic [2:0][31:0] rdbgAddr;
    logic [2:0][31:0] rdbgData;
    logic [2:0][31:0] outAddr;
    logic [2:0][31:0] outData;
    logic [2:0][31:0] checksum;
    logic [2:0]       outValid;
    logic [2:0]       outLast;
    logic [2:0]       busy;
    logic [2:0]       done;

    logic [31:0]      pipeA;
    logic [31:0]      pipeC;
    logic [2:0][31:0] pipeB;

    int          checks = 0;
    int          errors = 0;
    exp_t        sb[$];
    logic [31:0] expSum;

    int          cntOf[3]    = '{4, 2, 2};
    logic [31:0] baseOf[3]   = '{32'h0, 32'h0040_0000, 32'hFFFF_FFFF};
    logic [31:0] strideOf[3] = '{32'd1, 32'd4, 32'd1};

    dbg_dump_reader #(.BASE_ADDR(32'h0), .COUNT(4), .STRIDE(32'd1), .READ_LAT(1)) dutA (
        .clk_100M(clk_100M), .rst_n(rst_n), .clk_en(clk_en), .start(startV[0]),
        .rdbg_addr(rdbgAddr[0]), .rdbg_data(rdbgData[0]),
        .out_valid(outValid[0]), .out_ready(out_ready), .out_addr(outAddr[0]),
        .out_data(outData[0]), .out_last(outLast[0]), .busy(busy[0]),
        .done(done[0]), .checksum(checksum[0])
    );

    dbg_dump_reader #(.BASE_ADDR(32'h0040_0000), .COUNT(2), .STRIDE(32'd4), .READ_LAT(3)) dutB (
        .clk_100M(clk_100M), .rst_n(rst_n), .clk_en(clk_en), .start(startV[1]),
        .rdbg_addr(rdbgAddr[1]), .rdbg_data(rdbgData[1]),
        .out_valid(outValid[1]), .out_ready(out_ready), .out_addr(outAddr[1]),
        .out_data(outData[1]), .out_last(outLast[1]), .busy(busy[1]),
        .done(done[1]), .checksum(checksum[1])
    );

    dbg_dump_reader #(.BASE_ADDR(32'hFFFF_FFFF), .COUNT(2), .STRIDE(32'd1), .READ_LAT(1)) dutC (
        .clk_100M(clk_100M), .rst_n(rst_n), .clk_en(clk_en), .start(startV[2]),
        .rdbg_addr(rdbgAddr[2]), .rdbg_data(rdbgData[2]),
        .out_valid(outValid[2]), .out_ready(out_ready), .out_addr(outAddr[2]),
        .out_data(outData[2]), .out_last(outLast[2]), .busy(busy[2]),
        .done(done[2]), .checksum(checksum[2])
    );

    // Read data lags the address by READ_LAT enabled cycles; an early capture sees the previous word.
    always @(posedge clk_100M) begin
        if (clk_en) begin
            pipeA <= rdbgAddr[0];
            pipeB <= {pipeB[1:0], rdbgAddr[1]};
            pipeC <= rdbgAddr[2];
        end
    end

    assign rdbgData[0] = pipeA * 32'h1111_1111;
    assign rdbgData[1] = pipeB[2] * 32'h1111_1111;
    assign rdbgData[2] = pipeC * 32'h1111_1111;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] expChecksum();
`ifdef DBG_DUMP_CHECKSUM_EN
        return expSum;
`else
        return 32'h0;
`endif
    endfunction

    // Queue every word the dump should produce, then raise start for the selected instance.
    task automatic applyStimulus(input int s);
        logic [31:0] a;
        exp_t        e;
        expSum = 32'h0;
        for (int i = 0; i < cntOf[s]; i++) begin
            a      = baseOf[s] + strideOf[s] * 32'(i);
            e.addr = a;
            e.data = a * 32'h1111_1111;
            e.last = (i == cntOf[s] - 1);
            expSum = expSum + e.data;
            sb.push_back(e);
        end
        startV[s] = 1'b1;
    endtask

    // Drives one dump from a negedge and pops the scoreboard on every accepted word.
    task automatic runDump(input int s, input int stallIdx, input int stallLen, input int abortIdx,
                           input int injectAt, input bit toggleEn,
                           output int firstValidCyc, output int doneCyc, output int doneCnt);
        int          cyc;
        int          got;
        int          stallLeft;
        bit          pend;
        bit          prevDone;
        bit          fin;
        bit          ready;
        bit          en;
        logic [31:0] pA;
        logic [31:0] pD;
        exp_t        e;
        cyc = 0; got = 0; stallLeft = stallLen;
        pend = 1'b0; prevDone = 1'b0; fin = 1'b0;
        pA = 32'h0; pD = 32'h0;
        firstValidCyc = -1; doneCyc = -1; doneCnt = 0;
        clk_en = 1'b1;
        out_ready = 1'b1;
        applyStimulus(s);
        while (!fin && cyc < 3000) begin
            @(negedge clk_100M);
            cyc++;
            if (cyc == 1) startV[s] = 1'b0;
            if (cyc == injectAt) startV[s] = 1'b1;
            if (cyc == injectAt + 2) startV[s] = 1'b0;
            if (pend) begin
                checkOutput("holdValid", 32'(outValid[s]), 32'd1);
                checkOutput("holdAddr", outAddr[s], pA);
                checkOutput("holdData", outData[s], pD);
            end
            if (done[s] && !prevDone) begin
                doneCnt++;
                if (doneCyc < 0) doneCyc = cyc;
            end
            prevDone = done[s];
            if (outValid[s] && firstValidCyc < 0) firstValidCyc = cyc;
            if (outValid[s] && got == abortIdx) begin
                fin = 1'b1;
            end else begin
                en    = toggleEn ? !clk_en : 1'b1;
                ready = 1'b1;
                if (outValid[s] && got == stallIdx && stallLeft > 0) begin
                    ready = 1'b0;
                    stallLeft--;
                end
                clk_en    = en;
                out_ready = ready;
                pend      = outValid[s] && !(ready && en);
                pA        = outAddr[s];
                pD        = outData[s];
                if (outValid[s] && ready && en) begin
                    checkOutput("wordExpected", 32'(sb.size() > 0), 32'd1);
                    if (sb.size() > 0) begin
                        e = sb.pop_front();
                        checkOutput("outAddr", outAddr[s], e.addr);
                        checkOutput("outData", outData[s], e.data);
                        checkOutput("outLast", 32'(outLast[s]), 32'(e.last));
                    end
                    got++;
                end
                fin = (doneCnt > 0) && !busy[s] && !done[s];
            end
        end
        checkOutput("withinBudget", 32'(fin), 32'd1);
        clk_en = 1'b1;
    endtask

    int fv;
    int dc;
    int dn;

    initial begin
        rst_n = 1'b0; clk_en = 1'b1; out_ready = 1'b0; startV = 3'b000;
        repeat (3) @(negedge clk_100M);
        checkOutput("rstAddrA", rdbgAddr[0], 32'h0);
        checkOutput("rstAddrB", rdbgAddr[1], 32'h0040_0000);
        checkOutput("rstAddrC", rdbgAddr[2], 32'hFFFF_FFFF);
        checkOutput("rstFlagsA", {28'h0, outValid[0], outLast[0], busy[0], done[0]}, 32'h0);
        checkOutput("rstOutAddrA", outAddr[0], 32'h0);
        checkOutput("rstOutDataA", outData[0], 32'h0);
        checkOutput("rstChecksumA", checksum[0], 32'h0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk_100M);

        $display("[TB] basic dump");
        runDump(0, -1, 0, -1, -1, 1'b0, fv, dc, dn);
        checkOutput("basicFirstValid", 32'(fv), 32'd3);
        checkOutput("basicDoneCycle", 32'(dc), 32'd13);
        checkOutput("basicDoneCount", 32'(dn), 32'd1);
        checkOutput("basicChecksum", checksum[0], expChecksum());
        checkOutput("basicSbEmpty", 32'(sb.size()), 32'd0);

        $display("[TB] backpressure");
        @(negedge clk_100M);
        runDump(0, 1, 5, -1, -1, 1'b0, fv, dc, dn);
        checkOutput("bpDoneCycle", 32'(dc), 32'd18);
        checkOutput("bpDoneCount", 32'(dn), 32'd1);
        checkOutput("bpChecksum", checksum[0], expChecksum());
        checkOutput("bpSbEmpty", 32'(sb.size()), 32'd0);

        $display("[TB] latency and stride");
        @(negedge clk_100M);
        runDump(1, -1, 0, -1, -1, 1'b0, fv, dc, dn);
        checkOutput("latFirstValid", 32'(fv), 32'd5);
        checkOutput("latDoneCycle", 32'(dc), 32'd11);
        checkOutput("latDoneCount", 32'(dn), 32'd1);
        checkOutput("latSbEmpty", 32'(sb.size()), 32'd0);

        $display("[TB] clock enable toggling");
        @(negedge clk_100M);
        runDump(0, -1, 0, -1, -1, 1'b1, fv, dc, dn);
        checkOutput("cenDoneCycle", 32'(dc), 32'd25);
        checkOutput("cenDoneCount", 32'(dn), 32'd1);
        checkOutput("cenChecksum", checksum[0], expChecksum());
        checkOutput("cenSbEmpty", 32'(sb.size()), 32'd0);

        $display("[TB] reset mid-operation");
        @(negedge clk_100M);
        runDump(0, -1, 0, 2, -1, 1'b0, fv, dc, dn);
        checkOutput("midPresentAddr", outAddr[0], 32'h2);
        checkOutput("midNoDone", 32'(dn), 32'd0);
        rst_n = 1'b0;
        #1;
        checkOutput("midRstFlags", {28'h0, outValid[0], outLast[0], busy[0], done[0]}, 32'h0);
        checkOutput("midRstAddr", rdbgAddr[0], 32'h0);
        checkOutput("midRstOutAddr", outAddr[0], 32'h0);
        checkOutput("midRstOutData", outData[0], 32'h0);
        checkOutput("midRstChecksum", checksum[0], 32'h0);
        sb.delete();
        repeat (2) @(negedge clk_100M);
        checkOutput("midRstDoneLow", 32'(done[0]), 32'd0);
        rst_n = 1'b1;
        runDump(0, -1, 0, -1, -1, 1'b0, fv, dc, dn);
        checkOutput("restartDoneCount", 32'(dn), 32'd1);
        checkOutput("restartChecksum", checksum[0], expChecksum());
        checkOutput("restartSbEmpty", 32'(sb.size()), 32'd0);

        $display("[TB] wrap and ignored start");
        @(negedge clk_100M);
        runDump(2, -1, 0, -1, 4, 1'b0, fv, dc, dn);
        checkOutput("wrapDoneCycle", 32'(dc), 32'd7);
        checkOutput("wrapDoneCount", 32'(dn), 32'd1);
        checkOutput("wrapSbEmpty", 32'(sb.size()), 32'd0);
        repeat (3) @(negedge clk_100M);
        checkOutput("wrapStaysIdle", 32'(busy[2]), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
